sat_frame_ctrl: RTL

Frame-level sequencer for the saturation-estimation stage (`calc_sat`). It owns the atmospheric-light vector A that is driven into the stage. A new A estimate is shadowed and is applied only between frames, so one frame never sees two A values. After A is switched, the block waits out the registered inverse-A LUT latency before it admits pixels. It then counts pixels in and results out, drains the 7-cycle pipeline, and signals frame completion.

---
 rtl/sat_frame_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sat_frame_ctrl.sv
// Frame sequencer for calc_sat: shadows A between frames, waits out the inverse-A LUT settle, counts pixels and results.
// Optional drain watchdog is enabled by defining SAT_CTRL_WDOG_EN.
module sat_frame_ctrl #(
  parameter int         IMG_W    = 640,
  parameter int         IMG_H    = 480,
  parameter int         PIPE_LAT = 7,
  parameter logic [7:0] A_RESET  = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [7:0] A_new_r,
  input  logic [7:0] A_new_g,
  input  logic [7:0] A_new_b,
  input  logic       A_new_valid,
  output logic [7:0] sat_in_r,
  output logic [7:0] sat_in_g,
  output logic [7:0] sat_in_b,
  output logic       sat_in_valid,
  output logic [7:0] sat_A_r,
  output logic [7:0] sat_A_g,
  output logic [7:0] sat_A_b,
  output logic       sat_A_valid,
  input  logic       sat_out_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       err
);
  localparam int            NPIX   = IMG_W * IMG_H;
  localparam int            CW     = $clog2(NPIX + 1);
  localparam logic [CW-1:0] NPIX_C = CW'(NPIX);

  if (PIPE_LAT < 1) begin : g_bad_pipe_lat
    $error("PIPE_LAT must be at least 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state;
  logic          load_cnt;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] out_cnt_nxt;
  logic [7:0]    shd_r, shd_g, shd_b;
  logic          a_pend;
  logic          accept, in_last, out_inc, drain_hit, wdog_hit, err_set, start_idle;

  assign accept      = pix_valid & pix_ready;
  assign in_last     = accept && (in_cnt == NPIX_C - CW'(1));
  assign out_inc     = sat_out_valid && (state == S_RUN || state == S_DRAIN) && (out_cnt != NPIX_C);
  assign out_cnt_nxt = out_cnt + CW'(out_inc);
  assign drain_hit   = (out_cnt_nxt == NPIX_C);
  assign start_idle  = frame_start && (state == S_IDLE);

  assign err_set = (frame_start && state != S_IDLE)
                || (sat_out_valid && (state == S_IDLE || state == S_LOAD_A || state == S_DONE))
                || (sat_out_valid && out_cnt == NPIX_C)
                || wdog_hit;

`ifdef SAT_CTRL_WDOG_EN
  localparam int WW = $clog2(PIPE_LAT + 4) + 1;
  logic [WW-1:0] wdog_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wdog_cnt <= '0;
    else if (state == S_DRAIN)
      wdog_cnt <= wdog_cnt + WW'(1);
    else
      wdog_cnt <= '0;
  end

  // Fires on the last DRAIN cycle of the allowed window unless the final result lands now.
  assign wdog_hit = (state == S_DRAIN) && !drain_hit && (wdog_cnt == WW'(PIPE_LAT + 3));
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      load_cnt     <= 1'b0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      shd_r        <= A_RESET;
      shd_g        <= A_RESET;
      shd_b        <= A_RESET;
      a_pend       <= 1'b0;
      sat_A_r      <= A_RESET;
      sat_A_g      <= A_RESET;
      sat_A_b      <= A_RESET;
      sat_A_valid  <= 1'b0;
      sat_in_r     <= '0;
      sat_in_g     <= '0;
      sat_in_b     <= '0;
      sat_in_valid <= 1'b0;
      pix_ready    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      err          <= 1'b0;
    end else begin
      frame_done   <= 1'b0;
      sat_in_valid <= accept;
      if (accept) begin
        sat_in_r <= pix_r;
        sat_in_g <= pix_g;
        sat_in_b <= pix_b;
        in_cnt   <= in_cnt + CW'(1);
      end
      if (out_inc) out_cnt <= out_cnt_nxt;
      if (err_set) err <= 1'b1;
      // A strobe coinciding with an accepted frame_start goes straight to the active set.
      if (A_new_valid && !start_idle) begin
        shd_r  <= A_new_r;
        shd_g  <= A_new_g;
        shd_b  <= A_new_b;
        a_pend <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state    <= S_LOAD_A;
            busy     <= 1'b1;
            load_cnt <= 1'b0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            a_pend   <= 1'b0;
            if (A_new_valid) begin
              sat_A_r <= A_new_r;
              sat_A_g <= A_new_g;
              sat_A_b <= A_new_b;
            end else if (a_pend) begin
              sat_A_r <= shd_r;
              sat_A_g <= shd_g;
              sat_A_b <= shd_b;
            end
          end
        end
        S_LOAD_A: begin
          if (load_cnt) begin
            state       <= S_RUN;
            pix_ready   <= 1'b1;
            sat_A_valid <= 1'b1;
          end else begin
            load_cnt <= 1'b1;
          end
        end
        S_RUN: begin
          if (in_last) begin
            state     <= S_DRAIN;
            pix_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (drain_hit || wdog_hit) begin
            state       <= S_DONE;
            frame_done  <= 1'b1;
            sat_A_valid <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
